// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_seq_pkg + move_sequencer
//
// Purpose: queues cube-rotation commands from a host in a small FIFO and
// issues them to the datapath decoder one at a time. Every rotation is
// followed by a CHECK op; the datapath answers with a zero flag one cycle
// later. The sequencer stops when the cube reports solved, or when the move
// limit is reached while still unsolved.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    host push handshake
//   cmd_data[11:0]         {opcode, dst, src}
//   run                    level enable for issuing moves
//   op[15:0], op_valid     instruction word to the decoder {op, dst, src1, src0}
//   zf                     datapath zero flag, valid the cycle after CHECK
//   busy                   FSM is not IDLE
//   solved, abort, bad_cmd sticky status flags
//   move_count[7:0]        rotations issued since reset or clear (saturating)
//   clear                  synchronous clear of flags, move_count and FIFO
// -----------------------------------------------------------------------------

package move_seq_pkg;

  // Shared opcode encodings for the decoder instruction word.
  localparam logic [3:0] OPC_RX90  = 4'h1;
  localparam logic [3:0] OPC_RX180 = 4'h2;
  localparam logic [3:0] OPC_RX270 = 4'h3;
  localparam logic [3:0] OPC_RY90  = 4'h4;
  localparam logic [3:0] OPC_RY180 = 4'h5;
  localparam logic [3:0] OPC_RY270 = 4'h6;
  localparam logic [3:0] OPC_RZ90  = 4'h7;
  localparam logic [3:0] OPC_RZ180 = 4'h8;
  localparam logic [3:0] OPC_CHECK = 4'hC;
  localparam logic [3:0] OPC_JMP   = 4'hE;

  // Only rotations may enter the command FIFO.
  function automatic logic is_rotation(input logic [3:0] opc);
    case (opc)
      OPC_RX90, OPC_RX180, OPC_RX270,
      OPC_RY90, OPC_RY180, OPC_RY270,
      OPC_RZ90, OPC_RZ180: is_rotation = 1'b1;
      default:             is_rotation = 1'b0;
    endcase
  endfunction

endpackage : move_seq_pkg

module move_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  MAX_MOVES  = 8'd200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [11:0] cmd_data,
  input  logic        run,
  output logic [15:0] op,
  output logic        op_valid,
  input  logic        zf,
  output logic        busy,
  output logic        solved,
  output logic        abort,
  output logic        bad_cmd,
  output logic [7:0]  move_count,
  input  logic        clear
);

  import move_seq_pkg::*;

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) ||
      ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("move_sequencer: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    WAIT_ZF,
    HALT
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_e             r_state;
  state_e             w_state_nxt;

  logic [11:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [3:0]         r_last_dst;
  logic [7:0]         r_move_count;
  logic               r_solved;
  logic               r_abort;
  logic               r_bad_cmd;

  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_accept;
  logic               w_legal;
  logic               w_push;
  logic [11:0]        w_head;
  logic               w_hit_limit;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_head  = r_mem[r_rd_ptr];

  // ISSUE is the only consumer; clear wins over the pop.
  assign w_pop    = (r_state == ISSUE) && !w_empty && !clear;

  // A full FIFO still takes a command on the cycle its head is popped, so the
  // freed slot is refilled without a bubble and the occupancy stays constant.
  assign cmd_ready = !clear && (!w_full || w_pop);

  // Illegal opcodes complete the handshake but are never stored.
  assign w_accept = cmd_valid && cmd_ready;
  assign w_legal  = is_rotation(cmd_data[11:8]);
  assign w_push   = w_accept && w_legal;

  // NOTE: the storage array carries no reset; occupancy is tracked by the
  // pointers and count, so stale entries are never observable and the array
  // can map onto plain RAM/register-file cells.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cmd_data;
    end
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      // Empty by catching the read pointer up; the write pointer keeps
      // running so wrap-around is exercised across clears as well.
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  assign w_hit_limit = (r_move_count == MAX_MOVES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    op_valid    = 1'b0;
    op          = 16'h0000;

    unique case (r_state)
      IDLE: begin
        // run is only looked at here and in WAIT_ZF, so dropping it never
        // cuts an ISSUE/CHECK/WAIT_ZF triple short.
        if (run && !w_empty && !r_solved && !r_abort) begin
          w_state_nxt = ISSUE;
        end
      end

      ISSUE: begin
        op_valid    = 1'b1;
        op          = {w_head, 4'h0};
        w_state_nxt = CHECK;
      end

      CHECK: begin
        op_valid    = 1'b1;
        op          = {OPC_CHECK, r_last_dst, 8'h00};
        w_state_nxt = WAIT_ZF;
      end

      WAIT_ZF: begin
        if (zf || w_hit_limit) begin
          w_state_nxt = HALT;
        end else if (run && !w_empty) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end

      HALT: begin
        w_state_nxt = HALT;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // clear overrides any transition, including leaving HALT.
    if (clear) begin
      w_state_nxt = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Move bookkeeping and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_dst   <= 4'h0;
      r_move_count <= 8'h00;
      r_solved     <= 1'b0;
      r_abort      <= 1'b0;
      r_bad_cmd    <= 1'b0;
    end else if (clear) begin
      r_move_count <= 8'h00;
      r_solved     <= 1'b0;
      r_abort      <= 1'b0;
      r_bad_cmd    <= 1'b0;
    end else begin
      if (r_state == ISSUE) begin
        // CHECK names the destination register of the rotation just issued.
        r_last_dst <= w_head[7:4];
        if (r_move_count != 8'hFF) begin
          r_move_count <= r_move_count + 8'd1;
        end
      end
      if (r_state == WAIT_ZF) begin
        if (zf) begin
          r_solved <= 1'b1;
        end else if (w_hit_limit) begin
          r_abort <= 1'b1;
        end
      end
      if (w_accept && !w_legal) begin
        r_bad_cmd <= 1'b1;
      end
    end
  end

  assign busy       = (r_state != IDLE);
  assign solved     = r_solved;
  assign abort      = r_abort;
  assign bad_cmd    = r_bad_cmd;
  assign move_count = r_move_count;

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_op_quiet: assert property (@(posedge clk) disable iff (!rst_n)
    !op_valid |-> (op == 16'h0000));

  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CNT_W'(FIFO_DEPTH));

  a_no_issue_empty: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ISSUE) |-> !w_empty);

endmodule : move_sequencer

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer
//
// Directed bench for move_sequencer (FIFO_DEPTH=8, MAX_MOVES=3). A model built
// from queues predicts, per cycle, the op stream, handshake and status
// outputs; a compare process checks the DUT against it on every falling edge.
// Directed sequences add hand-computed literal expectations.
// Inputs change 2 time units after a rising edge.
// -----------------------------------------------------------------------------
module tb_move_sequencer;

  import move_seq_pkg::*;

  localparam int         DEPTH = 8;
  localparam logic [7:0] MAXM  = 8'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_data = 12'h000;
  logic        run = 1'b0;
  logic [15:0] op;
  logic        op_valid;
  logic        zf = 1'b0;
  logic        busy;
  logic        solved;
  logic        abort;
  logic        bad_cmd;
  logic [7:0]  move_count;
  logic        clear = 1'b0;

  always #5 clk = ~clk;

  move_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .MAX_MOVES  (MAXM)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .run        (run),
    .op         (op),
    .op_valid   (op_valid),
    .zf         (zf),
    .busy       (busy),
    .solved     (solved),
    .abort      (abort),
    .bad_cmd    (bad_cmd),
    .move_count (move_count),
    .clear      (clear)
  );

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a queue of stored commands and a schedule of the cycles still owed
  // by the move in flight (rotation word, check word, zero-flag wait).
  // ---------------------------------------------------------------------------
  typedef enum int {K_ROT, K_CHK, K_WAIT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [15:0] word;
  } slot_t;

  logic [11:0] mq[$];
  slot_t       sched[$];
  bit          m_solved, m_abort, m_bad, m_halt;
  logic [7:0]  m_cnt;

  function automatic bit legal_opc(input logic [3:0] o);
    return o inside {OPC_RX90, OPC_RX180, OPC_RX270, OPC_RY90,
                     OPC_RY180, OPC_RY270, OPC_RZ90, OPC_RZ180};
  endfunction

  function automatic bit m_ready();
    bit popping;
    popping = (sched.size() != 0) && (sched[0].kind == K_ROT);
    return !clear && ((mq.size() < DEPTH) || popping);
  endfunction

  task automatic m_reset();
    mq.delete();
    sched.delete();
    m_solved = 1'b0;
    m_abort  = 1'b0;
    m_bad    = 1'b0;
    m_halt   = 1'b0;
    m_cnt    = 8'h00;
  endtask

  task automatic m_start();
    logic [11:0] c;
    c = mq[0];
    sched.push_back('{K_ROT,  {c, 4'h0}});
    sched.push_back('{K_CHK,  {OPC_CHECK, c[7:4], 8'h00}});
    sched.push_back('{K_WAIT, 16'h0000});
  endtask

  task automatic m_step();
    bit    was_empty;
    bit    acc;
    slot_t s;
    was_empty = (mq.size() == 0);
    acc       = cmd_valid && m_ready();
    if (clear) begin
      m_reset();
    end else begin
      if (sched.size() != 0) begin
        s = sched.pop_front();
        if (s.kind == K_ROT) begin
          void'(mq.pop_front());
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        end else if (s.kind == K_WAIT) begin
          if (zf) begin
            m_solved = 1'b1;
            m_halt   = 1'b1;
          end else if (m_cnt == MAXM) begin
            m_abort = 1'b1;
            m_halt  = 1'b1;
          end else if (run && !was_empty) begin
            m_start();
          end
        end
      end else if (!m_halt) begin
        if (run && !was_empty && !m_solved && !m_abort) m_start();
      end
      if (acc) begin
        if (legal_opc(cmd_data[11:8])) mq.push_back(cmd_data);
        else m_bad = 1'b1;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Compare process: every falling edge.
  task automatic compare_all();
    bit          e_vld;
    logic [15:0] e_op;
    e_vld = (sched.size() != 0) && (sched[0].kind != K_WAIT);
    e_op  = e_vld ? sched[0].word : 16'h0000;
    check("op_valid",   32'(op_valid),   32'(e_vld));
    check("op",         32'(op),         32'(e_op));
    check("cmd_ready",  32'(cmd_ready),  32'(m_ready()));
    check("busy",       32'(busy),       32'((sched.size() != 0) || m_halt));
    check("solved",     32'(solved),     32'(m_solved));
    check("abort",      32'(abort),      32'(m_abort));
    check("bad_cmd",    32'(bad_cmd),    32'(m_bad));
    check("move_count", 32'(move_count), 32'(m_cnt));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_all();
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end 2 units after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [11:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_op_valid",   32'(op_valid),   32'd0);
    check("rst_move_count", 32'(move_count), 32'd0);
    tick();

    // 1: single RX90 dst=1 src=1, run high, zf low.
    run = 1'b1;
    push(12'h111);
    @(negedge clk);
    check("t1_lat_c1_valid", 32'(op_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_rot_valid", 32'(op_valid), 32'd1);
    check("t1_rot_op",    32'(op),       32'h1110);
    tick();
    @(negedge clk);
    check("t1_chk_op", 32'(op), 32'hC100);
    tick();
    @(negedge clk);
    check("t1_wait_valid", 32'(op_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_idle_busy", 32'(busy),       32'd0);
    check("t1_count",     32'(move_count), 32'd1);
    tick();
    do_clear();

    // 2: three moves queued, solved at the second check.
    run = 1'b0;
    push(12'h211);
    push(12'h432);
    push(12'h754);
    run = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) begin
        @(negedge clk);
        check("t2_chk2_op", 32'(op), 32'hC300);
      end
      if (i == 6) zf = 1'b1;
    end
    tick();
    zf = 1'b0;
    @(negedge clk);
    check("t2_solved",     32'(solved),     32'd1);
    check("t2_count",      32'(move_count), 32'd2);
    check("t2_model_left", 32'(mq.size()),  32'd1);
    repeat (5) tick();
    do_clear();

    // 4: JMP is dropped and flagged.
    push({OPC_JMP, 8'h12});
    @(negedge clk);
    check("t4_bad_cmd",     32'(bad_cmd),   32'd1);
    check("t4_model_empty", 32'(mq.size()), 32'd0);
    repeat (4) tick();
    do_clear();

    // 3: fill, push+pop at full, pointer wrap, then abort at the limit.
    run = 1'b0;
    for (int i = 0; i < 8; i++) push({4'(i + 1), 4'(i), 4'(15 - i)});
    @(negedge clk);
    check("t3_full_ready", 32'(cmd_ready), 32'd0);
    tick();
    push(12'h5EE);                      // offered while full, not taken
    run       = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 12'h3AB;
    tick();
    @(negedge clk);
    check("t3_pop_ready", 32'(cmd_ready), 32'd1);
    check("t3_pop_op",    32'(op),        32'h10F0);
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t3_refull_ready", 32'(cmd_ready), 32'd0);
    check("t3_model_cnt8",   32'(mq.size()), 32'd8);
    for (int i = 0; i < 10; i++) begin
      tick();
      cmd_valid = 1'b1;
      cmd_data  = {4'(1 + (i % 8)), 4'(i), 4'(i)};
    end
    tick();
    cmd_valid = 1'b0;
    @(negedge clk);
    check("t3_abort", 32'(abort),      32'd1);
    check("t3_count", 32'(move_count), 32'd3);
    tick();
    do_clear();
    run = 1'b0;
    for (int i = 0; i < 8; i++) push({4'(8 - i), 4'(i), 4'(i)});
    @(negedge clk);
    check("t3_wrap_full_ready", 32'(cmd_ready), 32'd0);
    tick();
    do_clear();

    // 5: five moves, zf low, abort after the third.
    for (int i = 0; i < 5; i++) push({4'(i + 4), 4'(i + 2), 4'(i)});
    run = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    check("t5_abort",      32'(abort),      32'd1);
    check("t5_busy",       32'(busy),       32'd1);
    check("t5_count",      32'(move_count), 32'd3);
    check("t5_model_left", 32'(mq.size()),  32'd2);
    repeat (4) tick();
    do_clear();
    @(negedge clk);
    check("t5_clr_busy",  32'(busy),      32'd0);
    check("t5_clr_abort", 32'(abort),     32'd0);
    check("t5_clr_ready", 32'(cmd_ready), 32'd1);
    check("t5_clr_empty", 32'(mq.size()), 32'd0);
    repeat (4) tick();

    // 6: reset during CHECK drops the move and the queue.
    run = 1'b0;
    push(12'h811);
    push(12'h622);
    run = 1'b1;
    tick();
    tick();
    #1;
    check("t6_in_check", 32'(op), 32'hC100);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(op_valid),   32'd0);
    check("t6_rst_op",    32'(op),         32'd0);
    check("t6_rst_busy",  32'(busy),       32'd0);
    check("t6_rst_count", 32'(move_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    check("t6_post_busy",  32'(busy),      32'd0);
    check("t6_post_ready", 32'(cmd_ready), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_move_sequencer
